// File: rtl/ppu_pkg.sv
// Shared types for the PPU VRAM arbiter: arbitration mode, CPU read FSM states
// and per-cycle bus owner.
package ppu_pkg;

  typedef enum logic {
    ARB_VBLANK,
    ARB_STEAL
  } arb_mode_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PEND,
    RD_ISSUED
  } rd_state_t;

  typedef enum logic [1:0] {
    GNT_RND,
    GNT_WR,
    GNT_RD
  } grant_t;

endpackage

// File: rtl/ppu_wr_fifo.sv
// Synchronous FIFO buffering CPU {addr,data} writes until the CPU side owns the bus.
// Push is refused while full (registered level), even if a pop happens that cycle.
module ppu_wr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (!do_push && do_pop) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// PPU memory-bus arbiter: renderer has absolute priority inside the render window,
// CPU writes are queued in a FIFO and CPU reads are serviced once the FIFO drains.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned VBLANK_LINE = 281,
  parameter arb_mode_t   MODE        = ARB_VBLANK
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          show_en,
  input  logic [9:0]                    vc,
  input  logic                          rnd_req,
  input  logic [ADDR_W-1:0]             rnd_addr,
  output logic [DATA_W-1:0]             rnd_data,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic                          cpu_ready,
  output logic                          cpu_rvalid,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          in_window
);

  localparam int unsigned ENT_W    = ADDR_W + DATA_W;
  localparam logic [9:0]  VC_LIMIT = 10'(VBLANK_LINE);

  logic              in_window_q;
  rd_state_t         rd_state;
  logic [ADDR_W-1:0] rd_addr;
  grant_t            gnt;
  logic              rnd_gnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              rd_accept;
  logic [ENT_W-1:0]  head;

  assign in_window = in_window_q;
  assign rnd_data  = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) in_window_q <= 1'b0;
    else       in_window_q <= show_en && (vc < VC_LIMIT);
  end

  // Renderer is never stalled; the CPU side only sees cycles the renderer gives up.
  assign rnd_gnt = in_window_q && ((MODE == ARB_VBLANK) || rnd_req);

  always_comb begin
    gnt = GNT_RND;
    if (!rnd_gnt) begin
      if (!fifo_empty)            gnt = GNT_WR;
      else if (rd_state == RD_PEND) gnt = GNT_RD;
    end
  end

  always_comb begin
    mem_addr  = rnd_addr;
    mem_we    = 1'b0;
    mem_wdata = head[DATA_W-1:0];
    case (gnt)
      GNT_WR: begin
        mem_addr = head[ENT_W-1:DATA_W];
        mem_we   = 1'b1;
      end
      GNT_RD:  mem_addr = rd_addr;
      default: ;
    endcase
  end

  // Reads wait for an empty FIFO so they observe every earlier write.
  assign cpu_ready = cpu_we ? !fifo_full : (fifo_empty && (rd_state == RD_IDLE));
  assign push      = cpu_req && cpu_we && !fifo_full;
  assign rd_accept = cpu_req && !cpu_we && fifo_empty && (rd_state == RD_IDLE);
  assign pop       = (gnt == GNT_WR);

  ppu_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({cpu_addr, cpu_wdata}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state   <= RD_IDLE;
      rd_addr    <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (rd_accept) begin
            rd_addr  <= cpu_addr;
            rd_state <= RD_PEND;
          end
        end
        RD_PEND: begin
          if (gnt == GNT_RD) rd_state <= RD_ISSUED;
        end
        RD_ISSUED: begin
          cpu_rdata  <= mem_rdata;
          cpu_rvalid <= 1'b1;
          rd_state   <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter: one VBLANK-mode and one STEAL-mode instance,
// each with a behavioural 1-cycle-latency memory and a write/read scoreboard.
module tb_ppu_vram_arbiter;
  import ppu_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        show_en = 1'b0;
  logic [9:0]  vc = '0;
  logic        rnd_req = 1'b0;
  logic [15:0] rnd_addr = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_req_vb = 1'b0;
  logic        cpu_req_st = 1'b0;

  logic [7:0]  rnd_data_vb, rnd_data_st;
  logic        cpu_ready_vb, cpu_ready_st;
  logic        cpu_rvalid_vb, cpu_rvalid_st;
  logic [7:0]  cpu_rdata_vb, cpu_rdata_st;
  logic [15:0] mem_addr_vb, mem_addr_st;
  logic        mem_we_vb, mem_we_st;
  logic [7:0]  mem_wdata_vb, mem_wdata_st;
  logic [7:0]  mem_rdata_vb = '0;
  logic [7:0]  mem_rdata_st = '0;
  logic [3:0]  fifo_level_vb, fifo_level_st;
  logic        in_window_vb, in_window_st;

  logic [7:0]  mem_vb [65536];
  logic [7:0]  mem_st [65536];

  int n_assert = 0;
  int n_fail   = 0;

  wr_t        exp_wr_vb[$];
  wr_t        exp_wr_st[$];
  logic [7:0] exp_rd_vb[$];
  logic [7:0] exp_rd_st[$];

  always #5 clk = ~clk;

  ppu_vram_arbiter #(
    .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(8), .VBLANK_LINE(281), .MODE(ARB_VBLANK)
  ) u_vb (
    .clk(clk), .reset(reset), .show_en(show_en), .vc(vc),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_data(rnd_data_vb),
    .cpu_req(cpu_req_vb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready_vb), .cpu_rvalid(cpu_rvalid_vb), .cpu_rdata(cpu_rdata_vb),
    .mem_addr(mem_addr_vb), .mem_we(mem_we_vb), .mem_wdata(mem_wdata_vb),
    .mem_rdata(mem_rdata_vb), .fifo_level(fifo_level_vb), .in_window(in_window_vb)
  );

  ppu_vram_arbiter #(
    .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(8), .VBLANK_LINE(281), .MODE(ARB_STEAL)
  ) u_st (
    .clk(clk), .reset(reset), .show_en(show_en), .vc(vc),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_data(rnd_data_st),
    .cpu_req(cpu_req_st), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready_st), .cpu_rvalid(cpu_rvalid_st), .cpu_rdata(cpu_rdata_st),
    .mem_addr(mem_addr_st), .mem_we(mem_we_st), .mem_wdata(mem_wdata_st),
    .mem_rdata(mem_rdata_st), .fifo_level(fifo_level_st), .in_window(in_window_st)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Memory models: 1-cycle synchronous read, write on strobe.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_vb[i] = pat(16'(i));
      mem_st[i] = pat(16'(i));
    end
    mem_vb[16'h23C0] = 8'hA7;
    forever begin
      @(posedge clk);
      mem_rdata_vb <= mem_vb[mem_addr_vb];
      mem_rdata_st <= mem_st[mem_addr_st];
      if (mem_we_vb) mem_vb[mem_addr_vb] = mem_wdata_vb;
      if (mem_we_st) mem_st[mem_addr_st] = mem_wdata_st;
    end
  end

  // Scoreboard: expectations pushed at acceptance, popped when the DUT produces them.
  initial begin
    logic        prev_gnt_st;
    logic [15:0] prev_addr_st;
    wr_t         e;
    logic [7:0]  r;
    prev_gnt_st  = 1'b0;
    prev_addr_st = '0;
    forever begin
      smp();
      if (reset) begin
        exp_wr_vb.delete();
        exp_wr_st.delete();
        exp_rd_vb.delete();
        exp_rd_st.delete();
        prev_gnt_st = 1'b0;
      end else begin
        if (mem_we_vb) begin
          chk("vb_wr_expected", 32'(exp_wr_vb.size() != 0), 1);
          if (exp_wr_vb.size() != 0) begin
            e = exp_wr_vb.pop_front();
            chk("vb_wr_addr", mem_addr_vb, e.a);
            chk("vb_wr_data", mem_wdata_vb, e.d);
          end
        end
        if (cpu_rvalid_vb) begin
          chk("vb_rd_expected", 32'(exp_rd_vb.size() != 0), 1);
          if (exp_rd_vb.size() != 0) begin
            r = exp_rd_vb.pop_front();
            chk("vb_rd_data", cpu_rdata_vb, r);
          end
        end
        if (cpu_req_vb && cpu_ready_vb) begin
          if (cpu_we) exp_wr_vb.push_back({cpu_addr, cpu_wdata});
          else        exp_rd_vb.push_back(mem_vb[cpu_addr]);
        end
        if (mem_we_st) begin
          chk("st_wr_on_rnd_cycle", 32'(in_window_st && rnd_req), 0);
          chk("st_wr_expected", 32'(exp_wr_st.size() != 0), 1);
          if (exp_wr_st.size() != 0) begin
            e = exp_wr_st.pop_front();
            chk("st_wr_addr", mem_addr_st, e.a);
            chk("st_wr_data", mem_wdata_st, e.d);
          end
        end
        if (cpu_rvalid_st) begin
          chk("st_rd_expected", 32'(exp_rd_st.size() != 0), 1);
          if (exp_rd_st.size() != 0) begin
            r = exp_rd_st.pop_front();
            chk("st_rd_data", cpu_rdata_st, r);
          end
        end
        if (cpu_req_st && cpu_ready_st) begin
          if (cpu_we) exp_wr_st.push_back({cpu_addr, cpu_wdata});
          else        exp_rd_st.push_back(mem_st[cpu_addr]);
        end
        if (prev_gnt_st) chk("st_rnd_data", rnd_data_st, pat(prev_addr_st));
        prev_gnt_st  = in_window_st && rnd_req;
        prev_addr_st = rnd_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;

    // Reset values
    reset = 1'b1;
    next(); next();
    smp();
    chk("rst_rvalid",  cpu_rvalid_vb, 0);
    chk("rst_rdata",   cpu_rdata_vb,  0);
    chk("rst_level",   fifo_level_vb, 0);
    chk("rst_window",  in_window_vb,  0);
    chk("rst_mem_we",  mem_we_vb,     0);
    chk("rst_ready",   cpu_ready_vb,  1);
    chk("rst_level_st", fifo_level_st, 0);
    next();
    reset = 1'b0;

    // Single write outside the window
    show_en = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h55; cpu_req_vb = 1'b1;
    smp();
    chk("w1_ready", cpu_ready_vb, 1);
    chk("w1_no_we", mem_we_vb, 0);
    next();
    cpu_req_vb = 1'b0;
    smp();
    chk("w1_we",    mem_we_vb,     1);
    chk("w1_addr",  mem_addr_vb,   16'h2000);
    chk("w1_data",  mem_wdata_vb,  8'h55);
    chk("w1_level", fifo_level_vb, 1);
    next();
    smp();
    chk("w1_level0", fifo_level_vb, 0);
    chk("w1_we0",    mem_we_vb,     0);
    next();

    // Fill the FIFO inside the render window
    show_en = 1'b1; vc = 10'd100; rnd_addr = 16'h0011;
    next();
    smp();
    chk("win_on",       in_window_vb, 1);
    chk("win_rnd_addr", mem_addr_vb,  16'h0011);
    chk("win_no_we",    mem_we_vb,    0);
    next();
    for (int i = 0; i < 8; i++) begin
      cpu_we = 1'b1; cpu_addr = 16'h2100 + 16'(i); cpu_wdata = 8'h10 + 8'(i); cpu_req_vb = 1'b1;
      smp();
      chk("fill_ready", cpu_ready_vb, 1);
      chk("fill_no_we", mem_we_vb, 0);
      next();
    end
    cpu_addr = 16'h2F00; cpu_wdata = 8'hEE; vc = 10'd281;
    smp();
    chk("full_ready", cpu_ready_vb, 0);
    chk("full_level", fifo_level_vb, 8);
    chk("full_no_we", mem_we_vb, 0);
    next();
    // Drain; first drain cycle also attempts a push against a full FIFO
    for (int i = 0; i < 8; i++) begin
      cpu_req_vb = (i == 0);
      smp();
      chk("drain_we",    mem_we_vb,     1);
      chk("drain_addr",  mem_addr_vb,   16'h2100 + 16'(i));
      chk("drain_level", fifo_level_vb, 32'(8 - i));
      if (i == 0) chk("full_pop_push_ready", cpu_ready_vb, 0);
      next();
    end
    cpu_req_vb = 1'b0;
    smp();
    chk("drain_done_level", fifo_level_vb, 0);
    chk("drain_done_we",    mem_we_vb,     0);
    next();

    // Read queued behind two writes
    vc = 10'd100;
    next();
    for (int i = 0; i < 2; i++) begin
      cpu_we = 1'b1; cpu_addr = 16'h2200 + 16'(i); cpu_wdata = 8'h66 + 8'(17 * i); cpu_req_vb = 1'b1;
      smp();
      chk("raw_wr_ready", cpu_ready_vb, 1);
      next();
    end
    cpu_we = 1'b0; cpu_addr = 16'h23C0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("raw_rd_blocked", cpu_ready_vb, 0);
      chk("raw_level",      fifo_level_vb, 2);
      next();
    end
    vc = 10'd281;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      smp();
      if (cpu_ready_vb) begin
        got = 1'b1;
        chk("raw_accept_level", fifo_level_vb, 0);
      end else begin
        next();
      end
    end
    chk("raw_accept_in_time", 32'(got), 1);
    next();
    cpu_req_vb = 1'b0;
    smp();
    chk("rd_issue_we",   mem_we_vb,     0);
    chk("rd_issue_addr", mem_addr_vb,   16'h23C0);
    chk("rd_t1_rvalid",  cpu_rvalid_vb, 0);
    next();
    smp();
    chk("rd_t2_rvalid", cpu_rvalid_vb, 0);
    next();
    smp();
    chk("rd_t3_rvalid", cpu_rvalid_vb, 1);
    chk("rd_t3_rdata",  cpu_rdata_vb,  8'hA7);
    next();
    smp();
    chk("rd_t4_rvalid", cpu_rvalid_vb, 0);
    chk("rd_t4_hold",   cpu_rdata_vb,  8'hA7);
    next();

    // Cycle steal: writes only on rnd_req=0 cycles
    vc = 10'd50; rnd_req = 1'b1; rnd_addr = 16'h0003;
    next();
    for (int i = 0; i < 2; i++) begin
      cpu_we = 1'b1; cpu_addr = 16'h2300 + 16'(i); cpu_wdata = 8'h81 + 8'(i);
      cpu_req_st = 1'b1; rnd_addr = 16'(i + 5);
      smp();
      chk("st_push_ready", cpu_ready_st, 1);
      chk("st_push_no_we", mem_we_st, 0);
      next();
    end
    cpu_req_st = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd_req = ((i % 2) == 0);
      rnd_addr = 16'(7 * i + 20);
      smp();
      chk("st_we_pattern", mem_we_st, 32'(!rnd_req));
      if (rnd_req) chk("st_rnd_addr", mem_addr_st, rnd_addr);
      else         chk("st_wr_addr_seq", mem_addr_st, 16'h2300 + 16'(i / 2));
      next();
    end
    rnd_req = 1'b0;
    smp();
    chk("st_drained_level", fifo_level_st, 0);
    chk("st_drained_we",    mem_we_st,     0);
    next();

    // Reset while a read is in RD_ISSUED with a write queued
    rnd_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_req_st = 1'b1;
    smp();
    chk("rst_rd_accept", cpu_ready_st, 1);
    next();
    rnd_req = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h2400; cpu_wdata = 8'h91;
    smp();
    chk("rst_rd_issue_addr", mem_addr_st, 16'h0040);
    chk("rst_rd_issue_we",   mem_we_st,   0);
    next();
    rnd_req = 1'b1; cpu_req_st = 1'b0; reset = 1'b1;
    smp();
    chk("rst_issued_level", fifo_level_st, 1);
    next();
    reset = 1'b0; cpu_we = 1'b0;
    smp();
    chk("rst_mid_rvalid", cpu_rvalid_st, 0);
    chk("rst_mid_level",  fifo_level_st, 0);
    chk("rst_mid_we",     mem_we_st,     0);
    chk("rst_mid_ready",  cpu_ready_st,  1);
    next();
    smp();
    chk("rst_mid_rvalid2", cpu_rvalid_st, 0);
    next();

    smp();
    chk("sb_vb_empty", 32'(exp_wr_vb.size() + exp_rd_vb.size()), 0);
    chk("sb_st_empty", 32'(exp_wr_st.size() + exp_rd_st.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
